game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
Parametrised game-flow controller for the VGA shooter top level. It replaces the ad-hoc death/score/move logic with an FSM that handles rounds, lives, respawn delay, win/lose detection, per-frame move ticks and LFSR seed capture. It sits between the vga_timing outputs (pixpulse, vblank) and the sprite instances (paddle, bull, ene, enep), which consume move, round_rst, player_rst and seed.

Parameters:
N_ENEMY, 16, width of enemy_broken vector (number of enemy instances)
WIN_COUNT, 15, broken-enemy count that ends the round as a win
LIVES, 3, lives loaded at round start (≥1)
RESPAWN_FRAMES, 60, frame ticks spent in HIT before player respawns (≥1)
SCORE_W, 8, score output width
SEED_W, 2, LFSR seed width

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  reset, asynchronous, active-high
pixpulse  in  1  25 MHz pixel enable, one clk wide
vblank  in  1  vertical blanking from vga_timing
start  in  1  run switch, level
player_hit  in  1  player broken flag, level, sticky until player_rst
enemy_broken  in  N_ENEMY  per-enemy broken flags, level
lfsr_in  in  SEED_W  free-running LFSR value
move  out  1  one-clk sprite update pulse per frame while playing
round_rst  out  1  one-clk pulse resetting all sprites at round start
player_rst  out  1  one-clk pulse respawning the player
seed  out  SEED_W  LFSR value latched at round start
score  out  SCORE_W  popcount of enemy_broken, saturating
lives  out  $clog2(LIVES+1)  remaining lives
state  out  3  IDLE=0 PLAY=1 HIT=2 OVER=3 WIN=4
death  out  1  high in OVER
win  out  1  high in WIN
hiscore  out  SCORE_W  best score (see Optional Feature)

Behaviour:
- Reset: state IDLE; move, round_rst, player_rst, death, win = 0; seed, score, lives, hiscore = 0; vblank_d1 = 0; hit_d1 = 0.
- Frame tick: vblank_d1 <= vblank when pixpulse. tick = pixpulse & vblank & ~vblank_d1, exactly one clk per frame.
- Score: each clk, registered popcount of enemy_broken (1-clk latency). Saturates at 2^SCORE_W-1.
- Hit edge: hit_d1 <= player_hit every clk. hit_rise = player_hit & ~hit_d1.
- move is registered: move <= tick & start & (state==PLAY).
- IDLE: when start=1, seed <= lfsr_in, lives <= LIVES, round_rst pulses 1 clk, go to PLAY.
- PLAY: with start=0, stay in PLAY (paused, no move). Checks are evaluated in this priority order:
  - score ≥ WIN_COUNT -> WIN. Win beats a same-cycle hit.
  - else if hit_rise: lives <= lives-1. If lives was 1 -> OVER; else -> HIT with frame counter = RESPAWN_FRAMES.
- HIT: move=0. The counter decrements on each tick. When a tick arrives with counter==1, player_rst pulses 1 clk and the state returns to PLAY. player_hit is ignored throughout HIT, and hit_d1 keeps tracking.
- OVER: death=1, move=0. When start=0 -> IDLE, and death clears on the same edge.
- WIN: win=1, move=0. When start=0 -> IDLE.
- start dropping in HIT does not abort the countdown. Ticks are counted only while start=1.
- Mid-operation rst returns everything to reset values immediately. No pulse output is generated on rst release.
- round_rst and player_rst never assert in the same cycle.

Optional Feature:
GAME_CTRL_HISCORE_EN:
- Defined: on entry to OVER or WIN, hiscore <= max(hiscore, score). Only rst clears it; round_rst does not.
- Undefined: hiscore is tied to 0 and no register is inferred.

Test Plan:
- rst high, then low with start=0 -> state=0, move=0, lives=0. After start=1 and lfsr_in=2'b10 -> round_rst one pulse, seed=2, lives=3, state=1.
- In PLAY with start=1 over 3 vblank rises -> exactly 3 move pulses, each 1 clk. start=0 over 2 frames -> 0 pulses, state stays 1.
- enemy_broken 0x7FFF (15 bits set) -> score=15 next clk, then state=4 and win=1. In the same cycle player_hit rises -> WIN taken, lives unchanged.
- Three player_hit rises, each followed by the respawn wait -> lives 3→2→1, HIT lasts 60 ticks, player_rst after each of the first two. Third rise -> state=3, death=1. start=0 -> state=0, death=0.
- player_hit held high through HIT and past respawn -> no extra decrement until it falls and rises again. rst asserted mid-HIT -> all outputs 0 asynchronously.
- With GAME_CTRL_HISCORE_EN: round 1 ends with score 9 -> hiscore=9. Round 2 ends with score 4 -> hiscore stays 9. Without the macro -> hiscore=0 throughout.

Source files
------------

// File: rtl/game_ctrl_if.sv
// game_ctrl_if: signal bundle between game_ctrl and its surroundings.
//   master : the controller side (game_ctrl). It takes the timing, switch,
//            sprite-status and LFSR inputs, and drives the game-flow outputs.
//   slave  : the opposite side (top level / sprite fabric / testbench).
// Inputs to the controller : pixpulse, vblank, start, player_hit,
//                            enemy_broken[N_ENEMY], lfsr_in[SEED_W]
// Outputs from controller  : move, round_rst, player_rst, seed[SEED_W],
//                            score[SCORE_W], lives[$clog2(LIVES+1)],
//                            state[3], death, win, hiscore[SCORE_W]
interface game_ctrl_if #(
    parameter int N_ENEMY = 16,
    parameter int LIVES   = 3,
    parameter int SCORE_W = 8,
    parameter int SEED_W  = 2
);
    localparam int LIVES_W = $clog2(LIVES + 1);

    logic                pixpulse;
    logic                vblank;
    logic                start;
    logic                player_hit;
    logic [N_ENEMY-1:0]  enemy_broken;
    logic [SEED_W-1:0]   lfsr_in;

    logic                move;
    logic                round_rst;
    logic                player_rst;
    logic [SEED_W-1:0]   seed;
    logic [SCORE_W-1:0]  score;
    logic [LIVES_W-1:0]  lives;
    logic [2:0]          state;
    logic                death;
    logic                win;
    logic [SCORE_W-1:0]  hiscore;

    modport master (
        input  pixpulse, vblank, start, player_hit, enemy_broken, lfsr_in,
        output move, round_rst, player_rst, seed, score, lives, state,
               death, win, hiscore
    );

    modport slave (
        output pixpulse, vblank, start, player_hit, enemy_broken, lfsr_in,
        input  move, round_rst, player_rst, seed, score, lives, state,
               death, win, hiscore
    );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: game-flow controller for the VGA shooter. Handles rounds, lives,
// respawn delay, win/lose detection, per-frame move ticks and seed capture.
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   bus  - game_ctrl_if.master: pixpulse/vblank frame timing, start switch,
//          player_hit / enemy_broken sprite status, lfsr_in; drives move,
//          round_rst, player_rst, seed, score, lives, state, death, win,
//          hiscore.
// Optional feature: define GAME_CTRL_HISCORE_EN to keep a best-score register
// updated on entry to OVER or WIN; otherwise hiscore is constant 0.
module game_ctrl #(
    parameter int N_ENEMY        = 16,
    parameter int WIN_COUNT      = 15,
    parameter int LIVES          = 3,
    parameter int RESPAWN_FRAMES = 60,
    parameter int SCORE_W        = 8,
    parameter int SEED_W         = 2
) (
    input  logic        clk,
    input  logic        rst,
    game_ctrl_if.master bus
);
    localparam int LIVES_W = $clog2(LIVES + 1);
    localparam int CNT_W   = $clog2(RESPAWN_FRAMES + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PLAY = 3'd1,
        HIT  = 3'd2,
        OVER = 3'd3,
        WIN  = 3'd4
    } state_t;

    state_t              state_q, state_nx;
    logic [LIVES_W-1:0]  lives_q, lives_nx;
    logic [SEED_W-1:0]   seed_q, seed_nx;
    logic [CNT_W-1:0]    cnt_q, cnt_nx;
    logic [SCORE_W-1:0]  score_q, score_nx;
    logic                round_rst_q, round_rst_nx;
    logic                player_rst_q, player_rst_nx;
    logic                move_q, death_q, win_q;
    logic                vblank_d1, hit_d1;
    logic                tick, hit_rise;
    logic [31:0]         pop;

    // vblank_d1 is only updated on pixel enables, so the rising edge is
    // seen on exactly one pixpulse per frame.
    assign tick     = bus.pixpulse & bus.vblank & ~vblank_d1;
    assign hit_rise = bus.player_hit & ~hit_d1;

    // Saturating popcount of broken enemies.
    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < N_ENEMY; i++) begin
            pop = pop + 32'(bus.enemy_broken[i]);
        end
        if (pop > 32'((2 ** SCORE_W) - 1)) begin
            score_nx = '1;
        end else begin
            score_nx = pop[SCORE_W-1:0];
        end
    end

    always_comb begin
        state_nx      = state_q;
        lives_nx      = lives_q;
        seed_nx       = seed_q;
        cnt_nx        = cnt_q;
        round_rst_nx  = 1'b0;
        player_rst_nx = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    seed_nx      = bus.lfsr_in;
                    lives_nx     = LIVES_W'(LIVES);
                    round_rst_nx = 1'b1;
                    state_nx     = PLAY;
                end
            end
            PLAY: begin
                // Win is checked first so it beats a same-cycle hit.
                if (32'(score_q) >= 32'(WIN_COUNT)) begin
                    state_nx = WIN;
                end else if (hit_rise) begin
                    lives_nx = lives_q - LIVES_W'(1);
                    if (lives_q == LIVES_W'(1)) begin
                        state_nx = OVER;
                    end else begin
                        state_nx = HIT;
                        cnt_nx   = CNT_W'(RESPAWN_FRAMES);
                    end
                end
            end
            HIT: begin
                if (tick && bus.start) begin
                    if (cnt_q == CNT_W'(1)) begin
                        player_rst_nx = 1'b1;
                        state_nx      = PLAY;
                    end else begin
                        cnt_nx = cnt_q - CNT_W'(1);
                    end
                end
            end
            OVER, WIN: begin
                if (!bus.start) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            lives_q      <= '0;
            seed_q       <= '0;
            cnt_q        <= '0;
            score_q      <= '0;
            round_rst_q  <= 1'b0;
            player_rst_q <= 1'b0;
            move_q       <= 1'b0;
            death_q      <= 1'b0;
            win_q        <= 1'b0;
            vblank_d1    <= 1'b0;
            hit_d1       <= 1'b0;
        end else begin
            state_q      <= state_nx;
            lives_q      <= lives_nx;
            seed_q       <= seed_nx;
            cnt_q        <= cnt_nx;
            score_q      <= score_nx;
            round_rst_q  <= round_rst_nx;
            player_rst_q <= player_rst_nx;
            move_q       <= tick & bus.start & (state_q == PLAY);
            // Flags follow the next state so they clear on the exit edge.
            death_q      <= (state_nx == OVER);
            win_q        <= (state_nx == WIN);
            hit_d1       <= bus.player_hit;
            if (bus.pixpulse) begin
                vblank_d1 <= bus.vblank;
            end
        end
    end

`ifdef GAME_CTRL_HISCORE_EN
    logic [SCORE_W-1:0] hiscore_q;
    logic               enter_end;

    assign enter_end = (state_q == PLAY) && ((state_nx == OVER) || (state_nx == WIN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hiscore_q <= '0;
        end else if (enter_end && (score_q > hiscore_q)) begin
            hiscore_q <= score_q;
        end
    end

    assign bus.hiscore = hiscore_q;
`else
    assign bus.hiscore = '0;
`endif

    assign bus.move       = move_q;
    assign bus.round_rst  = round_rst_q;
    assign bus.player_rst = player_rst_q;
    assign bus.seed       = seed_q;
    assign bus.score      = score_q;
    assign bus.lives      = lives_q;
    assign bus.state      = state_q;
    assign bus.death      = death_q;
    assign bus.win        = win_q;
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: self-checking bench for game_ctrl. Frame timing is generated
// with a 4-clk pixel enable and an 8-pixel frame (vblank on pixels 5..7).
// Directed scenarios are followed by a randomized phase; every cycle the DUT
// outputs are compared with a behavioural model of the game rules.
module tb_game_ctrl;
    localparam int N_ENEMY = 16;
    localparam int WIN_CNT = 15;
    localparam int LIVES   = 3;
    localparam int RESP    = 60;
    localparam int SCORE_W = 8;
    localparam int SEED_W  = 2;
`ifdef GAME_CTRL_HISCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif
    localparam int S_IDLE = 0, S_PLAY = 1, S_HIT = 2, S_OVER = 3, S_WIN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    game_ctrl_if #(.N_ENEMY(N_ENEMY), .LIVES(LIVES), .SCORE_W(SCORE_W), .SEED_W(SEED_W)) bus ();

    game_ctrl #(
        .N_ENEMY(N_ENEMY), .WIN_COUNT(WIN_CNT), .LIVES(LIVES),
        .RESPAWN_FRAMES(RESP), .SCORE_W(SCORE_W), .SEED_W(SEED_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;
    int unsigned cyc = 0;
    int hit_ticks = 0;

    // Model state: game phase as plain integers.
    int m_state, m_lives, m_seed, m_cnt, m_score, m_hi;
    bit m_move, m_rr, m_pr, m_vb_prev, m_hit_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int hs(input int v);
        return HS_EN ? v : 0;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_lives = 0; m_seed = 0; m_cnt = 0; m_score = 0; m_hi = 0;
        m_move = 0; m_rr = 0; m_pr = 0; m_vb_prev = 0; m_hit_prev = 0;
    endtask

    task automatic model_edge();
        bit frame, rise;
        int prev_state;
        if (rst) begin
            model_reset();
            return;
        end
        frame = bus.pixpulse && bus.vblank && !m_vb_prev;
        if (bus.pixpulse) m_vb_prev = bus.vblank;
        rise = bus.player_hit && !m_hit_prev;
        m_hit_prev = bus.player_hit;
        m_move = frame && bus.start && (m_state == S_PLAY);
        m_rr = 0;
        m_pr = 0;
        prev_state = m_state;
        if (m_state == S_IDLE && bus.start) begin
            m_seed = int'(bus.lfsr_in); m_lives = LIVES; m_rr = 1; m_state = S_PLAY;
        end else if (m_state == S_PLAY) begin
            if (m_score >= WIN_CNT) m_state = S_WIN;
            else if (rise) begin
                m_lives = m_lives - 1;
                if (m_lives == 0) m_state = S_OVER;
                else begin m_state = S_HIT; m_cnt = RESP; end
            end
        end else if (m_state == S_HIT && frame && bus.start) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin m_pr = 1; m_state = S_PLAY; end
        end else if ((m_state == S_OVER || m_state == S_WIN) && !bus.start) begin
            m_state = S_IDLE;
        end
        if (HS_EN && prev_state == S_PLAY && (m_state == S_OVER || m_state == S_WIN))
            m_hi = (m_score > m_hi) ? m_score : m_hi;
        m_score = $countones(bus.enemy_broken);
        if (m_score > 255) m_score = 255;
    endtask

    task automatic compare_all();
        check("state", bus.state, m_state);
        check("move", bus.move, m_move);
        check("round_rst", bus.round_rst, m_rr);
        check("player_rst", bus.player_rst, m_pr);
        check("seed", bus.seed, m_seed);
        check("score", bus.score, m_score);
        check("lives", bus.lives, m_lives);
        check("death", bus.death, m_state == S_OVER);
        check("win", bus.win, m_state == S_WIN);
        check("hiscore", bus.hiscore, m_hi);
    endtask

    // One clock: model advances on the edge, outputs compared on the
    // falling edge, then the frame generator and LFSR move on.
    task automatic step();
        if (cyc % 32 == 20 && bus.state == 3'd2 && bus.start) hit_ticks++;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
        cyc++;
        bus.pixpulse = (cyc % 4 == 0);
        bus.vblank   = ((cyc / 4) % 8) >= 5;
        bus.lfsr_in  = SEED_W'($urandom);
    endtask

    task automatic hit_and_respawn(input int hold_after, input int exp_lives);
        int guard;
        bus.player_hit = 1'b1;
        hit_ticks = 0;
        step();
        check("hit_lives", bus.lives, exp_lives);
        check("hit_state", bus.state, S_HIT);
        guard = 0;
        while (bus.state == 3'd2 && guard < 4000) begin
            step();
            guard++;
        end
        check("respawn_in_time", guard < 4000, 1);
        check("respawn_pulse", bus.player_rst, 1);
        check("hit_ticks", hit_ticks, RESP);
        repeat (hold_after) step();
        check("no_extra_decrement", bus.lives, exp_lives);
        bus.player_hit = 1'b0;
        step();
    endtask

    task automatic play_to_over(input logic [N_ENEMY-1:0] eb, input int exp_hi);
        bus.start = 1'b1;
        step();
        check("round_start_lives", bus.lives, LIVES);
        bus.enemy_broken = eb;
        step();
        hit_and_respawn(0, 2);
        hit_and_respawn(40, 1);
        bus.player_hit = 1'b1;
        step();
        check("over_state", bus.state, S_OVER);
        check("over_death", bus.death, 1);
        check("over_lives", bus.lives, 0);
        check("over_hiscore", bus.hiscore, exp_hi);
        bus.start = 1'b0;
        bus.player_hit = 1'b0;
        step();
        check("over_exit_state", bus.state, S_IDLE);
        check("over_exit_death", bus.death, 0);
        bus.enemy_broken = '0;
    endtask

    initial begin
        int mv;
        model_reset();
        bus.pixpulse = 1'b1; bus.vblank = 1'b0; bus.start = 1'b0;
        bus.player_hit = 1'b0; bus.enemy_broken = '0; bus.lfsr_in = '0;

        repeat (3) step();
        rst = 1'b0;
        repeat (5) step();
        check("idle_state", bus.state, S_IDLE);
        check("idle_lives", bus.lives, 0);
        check("idle_move", bus.move, 0);

        // Round start with a known seed.
        bus.lfsr_in = 2'b10;
        bus.start = 1'b1;
        step();
        check("rr_pulse", bus.round_rst, 1);
        check("rr_seed", bus.seed, 2);
        check("rr_lives", bus.lives, 3);
        check("rr_state", bus.state, S_PLAY);
        step();
        check("rr_one_clk", bus.round_rst, 0);

        while (cyc % 32 != 0) step();
        mv = 0;
        repeat (96) begin step(); mv += int'(bus.move); end
        check("moves_3_frames", mv, 3);
        bus.start = 1'b0;
        mv = 0;
        repeat (64) begin step(); mv += int'(bus.move); end
        check("moves_paused", mv, 0);
        check("paused_state", bus.state, S_PLAY);

        // Round 1 continues: score 9, then three hits.
        bus.start = 1'b1;
        bus.enemy_broken = 16'h01FF;
        step();
        check("score_9", bus.score, 9);
        hit_and_respawn(0, 2);
        hit_and_respawn(40, 1);
        bus.player_hit = 1'b1;
        step();
        check("r1_over_state", bus.state, S_OVER);
        check("r1_over_death", bus.death, 1);
        check("r1_hiscore", bus.hiscore, hs(9));
        bus.start = 1'b0;
        bus.player_hit = 1'b0;
        step();
        check("r1_exit_state", bus.state, S_IDLE);
        check("r1_exit_death", bus.death, 0);
        bus.enemy_broken = '0;

        // Round 2: lower score must not lower the best score.
        play_to_over(16'h000F, hs(9));

        // Round 3: win beats a same-cycle hit.
        bus.start = 1'b1;
        step();
        bus.enemy_broken = 16'h7FFF;
        step();
        check("score_15", bus.score, 15);
        check("pre_win_state", bus.state, S_PLAY);
        bus.player_hit = 1'b1;
        step();
        check("win_state", bus.state, S_WIN);
        check("win_flag", bus.win, 1);
        check("win_lives", bus.lives, 3);
        check("win_hiscore", bus.hiscore, hs(15));
        bus.start = 1'b0;
        bus.player_hit = 1'b0;
        step();
        check("win_exit", bus.state, S_IDLE);
        bus.enemy_broken = '0;

        // Asynchronous reset in the middle of HIT.
        bus.start = 1'b1;
        step();
        bus.player_hit = 1'b1;
        step();
        check("pre_rst_hit", bus.state, S_HIT);
        repeat (10) step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("async_rst_lives", bus.lives, 0);
        bus.start = 1'b0;
        bus.player_hit = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();
        check("post_rst_rr", bus.round_rst, 0);
        check("post_rst_state", bus.state, S_IDLE);

        // Randomized play.
        bus.start = 1'b1;
        repeat (6000) begin
            if ($urandom_range(0, 299) == 0) bus.start = ~bus.start;
            if (!bus.player_hit && $urandom_range(0, 149) == 0) bus.player_hit = 1'b1;
            else if (bus.player_hit && (bus.player_rst || bus.round_rst || $urandom_range(0, 399) == 0))
                bus.player_hit = 1'b0;
            if (bus.round_rst) bus.enemy_broken = '0;
            else if ($urandom_range(0, 19) == 0)
                bus.enemy_broken[$urandom_range(0, N_ENEMY - 1)] = 1'b1;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
